// File: rtl/umi_mem.sv
// umi_mem: UMI-attached byte-addressable RAM with a buffered read-response path.
//
// Serves WRITE_POSTED (0x01) and READ_REQUEST (0x08) packets of size B = 2**size bytes, B <= W.
// Answers reads with WRITE_RESPONSE (0x05). Illegal requests (other opcodes, B > W, or a
// misaligned dstaddr) are accepted and dropped.
//
// Optional feature: define UMI_MEM_ERRCNT_EN to add the err_count output. It is a 16-bit
// saturating count of accepted illegal requests.
//
// Packet layout (256 bits):
//   [7:0] opcode, [11:8] size, [19:12] options, [31:20] burst,
//   [95:32] dstaddr, [159:96] srcaddr, [255:160] data (96 bits, little-endian at bit 160).
module umi_mem #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [255:0] umi_rx_packet,
  input  logic         umi_rx_valid,
  output logic         umi_rx_ready,
  output logic [255:0] umi_tx_packet,
  output logic         umi_tx_valid,
  input  logic         umi_tx_ready
`ifdef UMI_MEM_ERRCNT_EN
  ,
  output logic [15:0]  err_count
`endif
);

  localparam int unsigned WordBytes = DATA_WIDTH / 8;
  localparam int unsigned LaneBits  = $clog2(WordBytes);
  localparam int unsigned IdxW      = ADDR_WIDTH - LaneBits;
  localparam int unsigned NumWords  = 1 << IdxW;
  localparam int unsigned PtrW      = $clog2(RESP_DEPTH);

  localparam logic [7:0] OpWritePosted   = 8'h01;
  localparam logic [7:0] OpReadRequest   = 8'h08;
  localparam logic [7:0] OpWriteResponse = 8'h05;

  localparam logic [PtrW+1:0] DepthC = (PtrW + 2)'(RESP_DEPTH);

  // Request unpack
  logic [7:0]            req_opcode;
  logic [3:0]            req_size;
  logic [63:0]           req_dst;
  logic [63:0]           req_src;
  logic [DATA_WIDTH-1:0] req_data;

  assign req_opcode = umi_rx_packet[7:0];
  assign req_size   = umi_rx_packet[11:8];
  assign req_dst    = umi_rx_packet[95:32];
  assign req_src    = umi_rx_packet[159:96];

  // Request decode
  logic                  req_is_wr, req_is_rd, req_legal;
  logic [IdxW-1:0]       req_idx;
  logic [7:0]            req_lane;
  logic [WordBytes-1:0]  wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rx_fire, wr_en, rd_en, slot_free;

  // Read stage and FIFO state
  logic                  rd_busy_q;
  logic [7:0]            rd_lane_q;
  logic [3:0]            rd_size_q;
  logic [63:0]           rd_src_q, rd_dst_q;
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic [DATA_WIDTH-1:0] rd_shift, rd_data;
  logic [95:0]           resp_field;
  logic [255:0]          resp_pkt;

  logic [DATA_WIDTH-1:0] mem_q [NumWords];
  logic [255:0]          fifo_q [RESP_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         count_q, count_d;
  logic                  fifo_push, fifo_pop;
  logic [PtrW+1:0]       occupancy;

  // Decode legality, lane/word position and byte-enables of the head packet.
  always_comb begin
    req_is_wr = (req_opcode == OpWritePosted);
    req_is_rd = (req_opcode == OpReadRequest);
    req_legal = (req_is_wr || req_is_rd) && (req_size <= 4'(LaneBits)) &&
                ((req_dst & ((64'd1 << req_size) - 64'd1)) == 64'd0);
    req_idx   = req_dst[ADDR_WIDTH-1:LaneBits];
    req_lane  = req_dst[7:0] & 8'(WordBytes - 1);
    wr_data   = req_data << (8 * req_lane);
    for (int i = 0; i < int'(WordBytes); i++) begin
      wr_be[i] = (i >= int'(req_lane)) && (i < int'(req_lane) + (1 << req_size));
    end
  end

  // A read reserves its FIFO slot at handshake, so the in-flight read counts as occupied.
  assign occupancy    = {1'b0, count_q} + {{(PtrW + 1){1'b0}}, rd_busy_q};
  assign slot_free    = occupancy < DepthC;
  assign umi_rx_ready = !(req_is_rd && req_legal) || slot_free;
  assign rx_fire      = umi_rx_valid && umi_rx_ready;
  assign wr_en        = rx_fire && req_legal && req_is_wr;
  assign rd_en        = rx_fire && req_legal && req_is_rd;

  // Byte-lane writes and registered word read; memory contents have no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(WordBytes); i++) begin
      if (wr_en && wr_be[i]) begin
        mem_q[req_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (rd_en) begin
      rd_word_q <= mem_q[req_idx];
    end
  end

  // Read stage: remembers the request fields needed to build the response.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_busy_q <= 1'b0;
      rd_lane_q <= '0;
      rd_size_q <= '0;
      rd_src_q  <= '0;
      rd_dst_q  <= '0;
    end else begin
      rd_busy_q <= rd_en;
      if (rd_en) begin
        rd_lane_q <= req_lane;
        rd_size_q <= req_size;
        rd_src_q  <= req_src;
        rd_dst_q  <= req_dst;
      end
    end
  end

  // Shift the addressed lanes down to bit 0 and zero everything above B bytes.
  always_comb begin
    rd_shift = rd_word_q >> (8 * rd_lane_q);
    for (int i = 0; i < int'(WordBytes); i++) begin
      rd_data[8*i +: 8] = (i < (1 << rd_size_q)) ? rd_shift[8*i +: 8] : 8'h00;
    end
  end

  // Fit the word width to the 96-bit packet data field.
  if (DATA_WIDTH >= 96) begin : gen_wide_data
    logic unused_resp;
    assign req_data    = DATA_WIDTH'(umi_rx_packet[255:160]);
    assign resp_field  = rd_data[95:0];
    assign unused_resp = ^rd_data[DATA_WIDTH-1:96];
  end else begin : gen_narrow_data
    logic unused_req;
    assign req_data   = umi_rx_packet[160 +: DATA_WIDTH];
    assign resp_field = 96'(rd_data);
    assign unused_req = ^umi_rx_packet[255:160+DATA_WIDTH];
  end

  assign resp_pkt = {resp_field, rd_dst_q, rd_src_q, 12'd0, 8'd0, rd_size_q, OpWriteResponse};

  // FIFO bookkeeping
  assign fifo_push     = rd_busy_q;
  assign umi_tx_valid  = (count_q != '0);
  assign fifo_pop      = umi_tx_valid && umi_tx_ready;
  assign umi_tx_packet = fifo_q[rd_ptr_q];

  // Next occupancy; a push while full cannot happen because the slot was reserved.
  always_comb begin
    count_d = count_q;
    unique case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Response storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_q[wr_ptr_q] <= resp_pkt;
    end
  end

  // FIFO pointers and count; reset empties the FIFO and drops umi_tx_valid at once.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^umi_rx_packet[31:12];

`ifdef UMI_MEM_ERRCNT_EN
  logic [15:0] err_q;

  // Saturating count of accepted illegal requests.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_q <= '0;
    end else if (rx_fire && !req_legal && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_umi_mem.sv
// tb_umi_mem: scoreboard bench for umi_mem with a byte-array reference model.
module tb_umi_mem;

  localparam logic [7:0] OP_WP    = 8'h01;
  localparam logic [7:0] OP_RR    = 8'h08;
  localparam logic [7:0] OP_WRESP = 8'h05;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic [255:0] umi_rx_packet = '0;
  logic         umi_rx_valid = 1'b0;
  logic         umi_rx_ready;
  logic [255:0] umi_tx_packet;
  logic         umi_tx_valid;
  logic         umi_tx_ready = 1'b0;
`ifdef UMI_MEM_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  umi_mem #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(64),
    .RESP_DEPTH(4)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .umi_rx_packet(umi_rx_packet),
    .umi_rx_valid (umi_rx_valid),
    .umi_rx_ready (umi_rx_ready),
    .umi_tx_packet(umi_tx_packet),
    .umi_tx_valid (umi_tx_valid),
    .umi_tx_ready (umi_tx_ready)
`ifdef UMI_MEM_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           tests = 0;
  int           fails = 0;
  logic [255:0] sb [$];
  byte unsigned mem_m [1024];
  int           exp_err = 0;
  int           acc_cyc = 0;

  function automatic logic [255:0] pack(input logic [7:0] op, input logic [3:0] sz,
                                        input logic [63:0] dst, input logic [63:0] src,
                                        input logic [95:0] data);
    return {data, src, dst, 12'd0, 8'd0, sz, op};
  endfunction

  // Reference: apply an accepted request to the byte array, queue any response.
  function automatic void model_accept(input logic [7:0] op, input logic [3:0] sz,
                                       input logic [63:0] dst, input logic [63:0] src,
                                       input logic [95:0] data);
    int          b = 1 << sz;
    int          base = int'(dst[9:0]);
    logic [95:0] rd = '0;
    if (!((op == OP_WP || op == OP_RR) && b <= 8 && (dst % 64'(b)) == 0)) begin
      exp_err++;
      return;
    end
    if (op == OP_WP) begin
      for (int k = 0; k < b; k++) mem_m[base + k] = data[8*k +: 8];
    end else begin
      for (int k = 0; k < b; k++) rd[8*k +: 8] = mem_m[base + k];
      sb.push_back(pack(OP_WRESP, sz, src, dst, rd));
    end
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Present one request and wait (bounded) for its handshake. Call at posedge+1.
  task automatic send(input logic [7:0] op, input logic [3:0] sz, input logic [63:0] dst,
                      input logic [63:0] src, input logic [95:0] data);
    bit ok = 1'b0;
    umi_rx_packet = pack(op, sz, dst, src, data);
    umi_rx_valid  = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (umi_rx_ready) begin
        @(posedge clk);
        #1;
        ok      = 1'b1;
        acc_cyc = cyc - 1;
        model_accept(op, sz, dst, src, data);
      end
    end
    umi_rx_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL accept op=%h addr=%h got=no_handshake exp=handshake", op, dst);
    end
  endtask

  task automatic drain();
    umi_tx_ready = 1'b1;
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain_pending", sb.size(), 0);
    check("tx_valid_idle", umi_tx_valid, 1'b0);
  endtask

  // Monitor: compare every response handshake against the scoreboard head.
  initial begin
    logic [255:0] exp;
    forever begin
      @(negedge clk);
      if (nreset && umi_tx_valid && umi_tx_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp got=%h exp=none", umi_tx_packet);
        end else begin
          exp = sb.pop_front();
          if (umi_tx_packet !== exp) begin
            fails++;
            $display("FAIL resp_pkt got=%h exp=%h", umi_tx_packet, exp);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_hc, first_v, run, c0;
    bit done_run, stop;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_valid", umi_tx_valid, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_rx_ready", umi_rx_ready, 1'b1);
    check("reset_tx_valid_after", umi_tx_valid, 1'b0);

    // Fill the whole memory so every later read has a known value
    for (int i = 0; i < 128; i++) send(OP_WP, 4'd3, 64'(8 * i), 64'd0, {$urandom, $urandom, $urandom});

    // Full word, then byte-lane write and sub-word reads
    umi_tx_ready = 1'b1;
    send(OP_WP, 4'd3, 64'h10, 64'd0, 96'h1122334455667788);
    send(OP_RR, 4'd3, 64'h10, 64'hABC0, 96'd0);
    send(OP_WP, 4'd0, 64'h13, 64'd0, 96'hEE);
    send(OP_RR, 4'd1, 64'h12, 64'h1234, 96'd0);
    send(OP_RR, 4'd2, 64'h10, 64'h5678, 96'd0);
    drain();

    // Back-pressure: four reads fill the FIFO, the fifth stalls, a write still flows
    umi_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(OP_RR, 4'd3, 64'(32 + 8 * i), 64'(100 + i), 96'd0);
    umi_rx_packet = pack(OP_RR, 4'd3, 64'h40, 64'd104, 96'd0);
    umi_rx_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("read_stall_ready", umi_rx_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    umi_rx_valid = 1'b0;
    c0 = cyc;
    send(OP_WP, 4'd3, 64'h100, 64'd0, 96'hCAFE_F00D_1234_5678);
    check("write_during_stall", acc_cyc, c0);
    umi_tx_ready = 1'b1;
    send(OP_RR, 4'd3, 64'h40, 64'd104, 96'd0);
    send(OP_RR, 4'd3, 64'h48, 64'd105, 96'd0);
    drain();

    // Illegal requests: misaligned read, unknown opcode
    send(OP_RR, 4'd2, 64'h11, 64'd7, 96'd0);
    send(8'h55, 4'd3, 64'h18, 64'd8, 96'd0);
    repeat (6) @(posedge clk);
    #1;
    check("illegal_no_resp", umi_tx_valid, 1'b0);
`ifdef UMI_MEM_ERRCNT_EN
    check("err_count_illegal", err_count, 16'(exp_err));
`endif

    // Throughput: eight back-to-back reads
    first_hc = 0;
    first_v  = -1;
    run      = 0;
    done_run = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(OP_RR, 4'd3, 64'(8 * i), 64'(200 + i), 96'd0);
          if (i == 0) first_hc = acc_cyc;
        end
      end
      begin
        repeat (24) begin
          @(negedge clk);
          if (umi_tx_valid) begin
            if (first_v < 0) first_v = cyc;
            if (!done_run) run++;
          end else if (first_v >= 0) begin
            done_run = 1'b1;
          end
        end
      end
    join
    check("first_valid_latency", first_v, first_hc + 2);
    check("burst_len", run, 8);
    drain();

    // Randomized traffic with random tx back-pressure
    stop = 1'b0;
    fork
      begin
        for (int t = 0; t < 400; t++) begin
          int          r = $urandom_range(0, 99);
          logic [3:0]  sz = 4'($urandom_range(0, 3));
          int          b = 1 << sz;
          logic [63:0] dst = {32'($urandom), 22'($urandom), 10'($urandom_range(0, 1023) & ~(b - 1))};
          logic [63:0] src = {$urandom, $urandom};
          logic [95:0] dat = {$urandom, $urandom, $urandom};
          if (r < 45) begin
            send(OP_WP, sz, dst, src, dat);
          end else if (r < 90) begin
            send(OP_RR, sz, dst, src, dat);
          end else if (r < 94) begin
            send(8'h55, sz, dst, src, dat);
          end else if (r < 97) begin
            send(OP_RR, 4'd2, dst | 64'h1, src, dat);
          end else begin
            send(($urandom_range(0, 1) != 0) ? OP_RR : OP_WP, 4'd4, dst & ~64'hF, src, dat);
          end
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          umi_tx_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
`ifdef UMI_MEM_ERRCNT_EN
    check("err_count_total", err_count, 16'(exp_err));
`endif

    // Reset with three responses pending
    umi_tx_ready = 1'b0;
    send(OP_RR, 4'd3, 64'h10, 64'd1, 96'd0);
    send(OP_RR, 4'd3, 64'h18, 64'd2, 96'd0);
    send(OP_RR, 4'd3, 64'h20, 64'd3, 96'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    nreset = 1'b0;
    sb.delete();
    #1;
    check("reset_async_tx_valid", umi_tx_valid, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_rx_ready", umi_rx_ready, 1'b1);
    umi_tx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_no_stale", umi_tx_valid, 1'b0);
    send(OP_RR, 4'd3, 64'h10, 64'h77, 96'd0);
    send(OP_RR, 4'd0, 64'h105, 64'h78, 96'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
